// File: rtl/mem_access_stage.sv
// MEM pipeline stage with MEM/WB register: data-memory req/ready handshake, store lane
// steering, load formatting and write-back select. Optional misalignment trap: MISALIGN_TRAP_EN.
module mem_access_stage #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] alu_result_in,
  input  logic [31:0] reg_data2_in,
  input  logic [4:0]  rd_in,
  input  logic [2:0]  func3_in,
  input  logic [1:0]  wb_sel_in,
  input  logic [31:0] pc_in,
  input  logic        mem_read_in,
  input  logic        mem_write_in,
  input  logic        reg_write_in,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_be,
  output logic [31:0] dmem_wdata,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_ready,
  output logic        stall_out,
  output logic [31:0] wb_data_out,
  output logic [4:0]  rd_out,
  output logic        reg_write_out,
`ifdef MISALIGN_TRAP_EN
  output logic        misalign_out,
`endif
  output logic        bus_err_out
);

  typedef enum logic {S_IDLE, S_WAIT} state_t;

  localparam logic [15:0] TMO = 16'(TIMEOUT_CYCLES);

  state_t      state;
  logic [15:0] count;
  logic [1:0]  off;
  logic        mem_op;
  logic        misalign;
  logic        bus_op;
  logic        complete;
  logic        abort;
  logic [3:0]  store_be;
  logic [31:0] store_wdata;
  logic [31:0] load_data;
  logic [31:0] wb_data;

  assign off    = alu_result_in[1:0];
  assign mem_op = mem_read_in | mem_write_in;

`ifdef MISALIGN_TRAP_EN
  always_comb begin
    misalign = 1'b0;
    if (mem_op) begin
      case (func3_in[1:0])
        2'b01:   misalign = off[0];
        2'b10:   misalign = (off != 2'b00);
        default: misalign = 1'b0;
      endcase
    end
  end
`else
  assign misalign = 1'b0;
`endif

  assign bus_op = mem_op & ~misalign;

  // Request is qualified by reset so it falls immediately, even while upstream still holds mem_op.
  assign dmem_req  = ~reset & ((state == S_WAIT) | ((state == S_IDLE) & bus_op));
  assign dmem_we   = dmem_req & mem_write_in;
  assign dmem_addr = {alu_result_in[31:2], 2'b00};
  assign complete  = dmem_req & dmem_ready;
  assign abort     = (state == S_WAIT) & ~dmem_ready & (count == TMO);
  assign stall_out = dmem_req & ~dmem_ready & ~abort;

  always_comb begin
    store_be    = 4'hF;
    store_wdata = reg_data2_in;
    case (func3_in[1:0])
      2'b00: begin
        store_be    = 4'b0001 << off;
        store_wdata = {4{reg_data2_in[7:0]}};
      end
      2'b01: begin
        store_be    = 4'b0011 << {off[1], 1'b0};
        store_wdata = {2{reg_data2_in[15:0]}};
      end
      default: ;
    endcase
  end

  assign dmem_be    = !mem_op ? 4'h0 : (mem_write_in ? store_be : 4'hF);
  assign dmem_wdata = store_wdata;

  always_comb begin
    logic [7:0]  lane_b;
    logic [15:0] lane_h;
    lane_b    = 8'(dmem_rdata >> {off, 3'b000});
    lane_h    = off[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
    load_data = dmem_rdata;
    case (func3_in)
      3'b000:  load_data = {{24{lane_b[7]}}, lane_b};
      3'b001:  load_data = {{16{lane_h[15]}}, lane_h};
      3'b100:  load_data = {24'h0, lane_b};
      3'b101:  load_data = {16'h0, lane_h};
      default: load_data = dmem_rdata;
    endcase
  end

  always_comb begin
    wb_data = alu_result_in;
    case (wb_sel_in)
      2'b10:   wb_data = pc_in + 32'd4;
      2'b01:   wb_data = load_data;
      default: wb_data = alu_result_in;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= S_IDLE;
      count         <= '0;
      wb_data_out   <= '0;
      rd_out        <= '0;
      reg_write_out <= 1'b0;
      bus_err_out   <= 1'b0;
`ifdef MISALIGN_TRAP_EN
      misalign_out  <= 1'b0;
`endif
    end else begin
      bus_err_out <= abort;
`ifdef MISALIGN_TRAP_EN
      misalign_out <= misalign;
`endif
      case (state)
        S_IDLE: begin
          if (bus_op && !dmem_ready) begin
            state <= S_WAIT;
            count <= 16'd1;
          end
        end
        S_WAIT: begin
          if (dmem_ready || abort) begin
            state <= S_IDLE;
            count <= '0;
          end else begin
            count <= count + 16'd1;
          end
        end
        default: begin
          state <= S_IDLE;
          count <= '0;
        end
      endcase
      // Stalled and aborted slots become bubbles; data/rd hold their previous values.
      if (!bus_op || complete) begin
        wb_data_out   <= wb_data;
        rd_out        <= rd_in;
        reg_write_out <= reg_write_in & ~misalign;
      end else begin
        reg_write_out <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed bench for mem_access_stage with a 4-cycle timeout; expected values hand-computed.
module tb_mem_access_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] alu_result_in, reg_data2_in, pc_in, dmem_rdata;
  logic [4:0]  rd_in;
  logic [2:0]  func3_in;
  logic [1:0]  wb_sel_in;
  logic        mem_read_in, mem_write_in, reg_write_in, dmem_ready;
  logic        dmem_req, dmem_we, stall_out, reg_write_out, bus_err_out;
  logic [31:0] dmem_addr, dmem_wdata, wb_data_out;
  logic [3:0]  dmem_be;
  logic [4:0]  rd_out;

  int checks = 0;
  int fails  = 0;

  always #5 clk = ~clk;

  mem_access_stage #(.TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .reset(reset),
    .alu_result_in(alu_result_in), .reg_data2_in(reg_data2_in), .rd_in(rd_in),
    .func3_in(func3_in), .wb_sel_in(wb_sel_in), .pc_in(pc_in),
    .mem_read_in(mem_read_in), .mem_write_in(mem_write_in), .reg_write_in(reg_write_in),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_be(dmem_be),
    .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata), .dmem_ready(dmem_ready),
    .stall_out(stall_out), .wb_data_out(wb_data_out), .rd_out(rd_out),
    .reg_write_out(reg_write_out), .bus_err_out(bus_err_out)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input logic [31:0] alu, input logic [31:0] rs2, input logic [2:0] f3,
                        input logic [1:0] sel, input logic rd_, input logic wr, input logic [4:0] rd,
                        input logic rw);
    alu_result_in = alu; reg_data2_in = rs2; func3_in = f3; wb_sel_in = sel;
    mem_read_in = rd_; mem_write_in = wr; rd_in = rd; reg_write_in = rw;
  endtask

  initial begin
    reset = 1'b1;
    set_op(32'h0, 32'h0, 3'b000, 2'b00, 1'b0, 1'b0, 5'd0, 1'b0);
    pc_in = 32'h0; dmem_rdata = 32'h0; dmem_ready = 1'b0;
    step(); step();
    check("rst_wb", wb_data_out, 32'h0);
    check("rst_rd", 32'(rd_out), 32'h0);
    check("rst_rw", 32'(reg_write_out), 32'h0);
    check("rst_berr", 32'(bus_err_out), 32'h0);
    check("rst_req", 32'(dmem_req), 32'h0);
    reset = 1'b0;

    // SB x3=0xAABBCC11 to 0x103, zero-wait
    set_op(32'h103, 32'hAABBCC11, 3'b000, 2'b00, 1'b0, 1'b1, 5'd0, 1'b0);
    dmem_ready = 1'b1;
    #1;
    check("sb_req", 32'(dmem_req), 32'h1);
    check("sb_we", 32'(dmem_we), 32'h1);
    check("sb_be", 32'(dmem_be), 32'h8);
    check("sb_wdata", dmem_wdata, 32'h11111111);
    check("sb_addr", dmem_addr, 32'h100);
    check("sb_stall", 32'(stall_out), 32'h0);
    step();
    check("sb_rw", 32'(reg_write_out), 32'h0);

    // SH to 0x102 -> upper half lanes
    set_op(32'h102, 32'h1234ABCD, 3'b001, 2'b00, 1'b0, 1'b1, 5'd0, 1'b0);
    #1;
    check("sh_be", 32'(dmem_be), 32'hC);
    check("sh_wdata", dmem_wdata, 32'hABCDABCD);
    step();

    // SW to 0x101 -> low bits truncated
    set_op(32'h101, 32'hDEADBEEF, 3'b010, 2'b00, 1'b0, 1'b1, 5'd0, 1'b0);
    #1;
    check("sw_be", 32'(dmem_be), 32'hF);
    check("sw_addr", dmem_addr, 32'h100);
    check("sw_wdata", dmem_wdata, 32'hDEADBEEF);
    step();

    // LB from 0x102, ready on 4th cycle
    set_op(32'h102, 32'h0, 3'b000, 2'b01, 1'b1, 1'b0, 5'd5, 1'b1);
    dmem_ready = 1'b0; dmem_rdata = 32'h12F45678;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("lb_stall", 32'(stall_out), 32'h1);
      check("lb_be", 32'(dmem_be), 32'hF);
      check("lb_we", 32'(dmem_we), 32'h0);
      step();
    end
    check("lb_bubble", 32'(reg_write_out), 32'h0);
    dmem_ready = 1'b1;
    #1;
    check("lb_stall_end", 32'(stall_out), 32'h0);
    step();
    check("lb_wb", wb_data_out, 32'hFFFFFFF4);
    check("lb_rd", 32'(rd_out), 32'd5);
    check("lb_rw", 32'(reg_write_out), 32'h1);

    // LHU from 0x102
    set_op(32'h102, 32'h0, 3'b101, 2'b01, 1'b1, 1'b0, 5'd6, 1'b1);
    dmem_rdata = 32'h80010000;
    step();
    check("lhu_wb", wb_data_out, 32'h00008001);
    check("lhu_rd", 32'(rd_out), 32'd6);

    // LH from 0x100, sign-extended
    set_op(32'h100, 32'h0, 3'b001, 2'b01, 1'b1, 1'b0, 5'd9, 1'b1);
    dmem_rdata = 32'h00008001;
    step();
    check("lh_wb", wb_data_out, 32'hFFFF8001);

    // JAL link value wraps, no bus traffic
    set_op(32'h55, 32'h0, 3'b000, 2'b10, 1'b0, 1'b0, 5'd1, 1'b1);
    pc_in = 32'hFFFFFFFC; dmem_ready = 1'b0;
    #1;
    check("jal_req", 32'(dmem_req), 32'h0);
    check("jal_we", 32'(dmem_we), 32'h0);
    check("jal_stall", 32'(stall_out), 32'h0);
    step();
    check("jal_wb", wb_data_out, 32'h00000000);
    check("jal_rw", 32'(reg_write_out), 32'h1);
    check("jal_rd", 32'(rd_out), 32'd1);

    // ALU op, wb_sel 11 -> ALU result
    set_op(32'h12345678, 32'h0, 3'b000, 2'b11, 1'b0, 1'b0, 5'd2, 1'b1);
    step();
    check("alu_wb", wb_data_out, 32'h12345678);

    // Timeout: ready never arrives
    set_op(32'h200, 32'h0, 3'b010, 2'b01, 1'b1, 1'b0, 5'd7, 1'b1);
    dmem_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      check("to_stall", 32'(stall_out), 32'h1);
      check("to_berr_low", 32'(bus_err_out), 32'h0);
      step();
    end
    #1;
    check("to_abort_nostall", 32'(stall_out), 32'h0);
    step();
    check("to_berr", 32'(bus_err_out), 32'h1);
    check("to_rw", 32'(reg_write_out), 32'h0);
    check("to_rd_hold", 32'(rd_out), 32'd2);
    set_op(32'h0, 32'h0, 3'b000, 2'b00, 1'b0, 1'b0, 5'd0, 1'b0);
    #1;
    check("to_idle_req", 32'(dmem_req), 32'h0);
    step();
    check("to_berr_pulse", 32'(bus_err_out), 32'h0);

    // Reset asserted mid-WAIT
    set_op(32'h300, 32'h0, 3'b010, 2'b01, 1'b1, 1'b0, 5'd8, 1'b1);
    step();
    check("rw_req_wait", 32'(dmem_req), 32'h1);
    #2;
    reset = 1'b1;
    #1;
    check("rw_req", 32'(dmem_req), 32'h0);
    check("rw_stall", 32'(stall_out), 32'h0);
    check("rw_wb", wb_data_out, 32'h0);
    check("rw_rd", 32'(rd_out), 32'h0);
    check("rw_rw", 32'(reg_write_out), 32'h0);
    step();
    mem_read_in = 1'b0;
    reset = 1'b0;
    #1;
    check("rw_idle_req", 32'(dmem_req), 32'h0);
    step();

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
